// File: rtl/ram_data_sync_1r1w_if.sv
// ---------------------------------------------------------------------------
// ram_data_sync_1r1w_if
// Bus bundle for the 1-read/1-write synchronous data RAM.
//
// Optional feature macro: RAM_PARITY_EN (adds R0_perr).
//
// Signals (direction as seen by the RAM, i.e. the slave modport):
//   init_busy  out  high while the zero-initialisation sweep runs
//   R0_en      in   read request
//   R0_addr    in   read address
//   R0_valid   out  read data valid, one cycle after an accepted read
//   R0_data    out  registered read data
//   R0_oob     out  read address was out of range (qualifies R0_valid)
//   R0_perr    out  parity error on the read entry (RAM_PARITY_EN only)
//   W0_en      in   write request
//   W0_addr    in   write address
//   W0_data    in   write data
//   W0_ready   out  writes accepted (low during the init sweep)
// ---------------------------------------------------------------------------
interface ram_data_sync_1r1w_if #(
  parameter int WIDTH  = 65,
  parameter int ADDR_W = 3
);
  logic              init_busy;
  logic              R0_en;
  logic [ADDR_W-1:0] R0_addr;
  logic              R0_valid;
  logic [WIDTH-1:0]  R0_data;
  logic              R0_oob;
`ifdef RAM_PARITY_EN
  logic              R0_perr;
`endif
  logic              W0_en;
  logic [ADDR_W-1:0] W0_addr;
  logic [WIDTH-1:0]  W0_data;
  logic              W0_ready;

`ifdef RAM_PARITY_EN
  modport master (
    output R0_en, R0_addr, W0_en, W0_addr, W0_data,
    input  init_busy, R0_valid, R0_data, R0_oob, R0_perr, W0_ready
  );
  modport slave (
    input  R0_en, R0_addr, W0_en, W0_addr, W0_data,
    output init_busy, R0_valid, R0_data, R0_oob, R0_perr, W0_ready
  );
`else
  modport master (
    output R0_en, R0_addr, W0_en, W0_addr, W0_data,
    input  init_busy, R0_valid, R0_data, R0_oob, W0_ready
  );
  modport slave (
    input  R0_en, R0_addr, W0_en, W0_addr, W0_data,
    output init_busy, R0_valid, R0_data, R0_oob, W0_ready
  );
`endif
endinterface

// File: rtl/ram_data_sync_1r1w.sv
// ---------------------------------------------------------------------------
// ram_data_sync_1r1w
// Parametrised single-clock 1R1W data RAM with registered read, write-first
// bypass, a hardware zero-initialisation sweep after reset and out-of-range
// address detection for non-power-of-two depths.
//
// Optional feature macro: RAM_PARITY_EN
//   defined   : each entry carries an even-parity bit; R0_perr reports a
//               mismatch on normal in-range reads.
//   undefined : no parity storage, no R0_perr.
//
// Ports:
//   clock    in   single clock for all state
//   reset_n  in   synchronous active-low reset
//   bus      slave modport of ram_data_sync_1r1w_if (read/write ports,
//            init_busy, W0_ready, read results)
// ---------------------------------------------------------------------------
module ram_data_sync_1r1w #(
  parameter int  DEPTH  = 7,
  parameter int  WIDTH  = 65,
  localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  ram_data_sync_1r1w_if.slave   bus
);

`ifdef RAM_PARITY_EN
  localparam int MEM_W = WIDTH + 1;
`else
  localparam int MEM_W = WIDTH;
`endif

  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(DEPTH - 1);
  // One extra bit so DEPTH itself is representable for range compares.
  localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [ADDR_W-1:0] r_ptr;
  logic [ADDR_W-1:0] w_ptr_next;

  logic [MEM_W-1:0]  r_mem [DEPTH];

  logic              w_mem_we;
  logic [ADDR_W-1:0] w_mem_waddr;
  logic [MEM_W-1:0]  w_mem_wdata;

  logic              w_run;
  logic              w_wr_in_range;
  logic              w_rd_in_range;
  logic              w_rd_accept;
  logic              w_bypass;
  logic [MEM_W-1:0]  w_rd_word;

  logic              r_valid;
  logic [WIDTH-1:0]  r_data;
  logic              r_oob;
`ifdef RAM_PARITY_EN
  logic              r_perr;
`endif

  assign w_run         = (r_state == ST_RUN);
  assign w_wr_in_range = ({1'b0, bus.W0_addr} < DEPTH_EXT);
  assign w_rd_in_range = ({1'b0, bus.R0_addr} < DEPTH_EXT);
  assign w_rd_accept   = w_run && bus.R0_en;
  // Write-first: a same-cycle in-range write to the read address wins.
  assign w_bypass      = bus.W0_en && w_wr_in_range && (bus.W0_addr == bus.R0_addr);
  assign w_rd_word     = r_mem[bus.R0_addr];

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state <= ST_INIT;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_next;
      r_ptr   <= w_ptr_next;
    end
  end

  // -------------------------------------------------------------------------
  // Next state and memory write port selection
  // -------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    w_ptr_next   = r_ptr;
    w_mem_we     = 1'b0;
    w_mem_waddr  = bus.W0_addr;
    w_mem_wdata  = '0;
    unique case (r_state)
      ST_INIT: begin
        // Sweep owns the write port; user writes are ignored here.
        w_mem_we    = reset_n;
        w_mem_waddr = r_ptr;
        w_mem_wdata = '0;
        if (r_ptr == LAST_IDX) begin
          w_state_next = ST_RUN;
          w_ptr_next   = '0;
        end else begin
          w_ptr_next   = r_ptr + 1'b1;
        end
      end
      ST_RUN: begin
        w_mem_we    = reset_n && bus.W0_en && w_wr_in_range;
        w_mem_waddr = bus.W0_addr;
`ifdef RAM_PARITY_EN
        w_mem_wdata = {^bus.W0_data, bus.W0_data};
`else
        w_mem_wdata = bus.W0_data;
`endif
      end
      default: begin
        w_state_next = ST_INIT;
        w_ptr_next   = '0;
      end
    endcase
  end

  // Storage array; reset deliberately leaves contents alone.
  always_ff @(posedge clock) begin
    if (w_mem_we) begin
      r_mem[w_mem_waddr] <= w_mem_wdata;
    end
  end

  // -------------------------------------------------------------------------
  // Registered read port. Results hold when no read is accepted.
  // -------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_oob   <= 1'b0;
`ifdef RAM_PARITY_EN
      r_perr  <= 1'b0;
`endif
    end else begin
      r_valid <= w_rd_accept;
      if (w_rd_accept) begin
        if (!w_rd_in_range) begin
          r_data <= '0;
          r_oob  <= 1'b1;
`ifdef RAM_PARITY_EN
          r_perr <= 1'b0;
`endif
        end else if (w_bypass) begin
          r_data <= bus.W0_data;
          r_oob  <= 1'b0;
`ifdef RAM_PARITY_EN
          r_perr <= 1'b0;
`endif
        end else begin
          r_data <= w_rd_word[WIDTH-1:0];
          r_oob  <= 1'b0;
`ifdef RAM_PARITY_EN
          r_perr <= (^w_rd_word[WIDTH-1:0]) ^ w_rd_word[WIDTH];
`endif
        end
      end
    end
  end

  assign bus.init_busy = (r_state == ST_INIT);
  assign bus.W0_ready  = (r_state == ST_RUN);
  assign bus.R0_valid  = r_valid;
  assign bus.R0_data   = r_data;
  assign bus.R0_oob    = r_oob;
`ifdef RAM_PARITY_EN
  assign bus.R0_perr   = r_perr;
`endif

endmodule

// File: tb/tb_ram_data_sync_1r1w.sv
// ---------------------------------------------------------------------------
// tb_ram_data_sync_1r1w
// Directed plus randomised bench for ram_data_sync_1r1w (DEPTH=7, WIDTH=65)
// with a behavioural reference model checked after every clock.
// ---------------------------------------------------------------------------
module tb_ram_data_sync_1r1w;
  localparam int DEPTH  = 7;
  localparam int WIDTH  = 65;
  localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic clk;
  logic rst_n;

  ram_data_sync_1r1w_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) bus ();

  ram_data_sync_1r1w #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clock   (clk),
    .reset_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model state
  logic [WIDTH-1:0] m_mem [DEPTH];
  bit               m_corrupt [DEPTH];
  int               m_init_left = DEPTH;
  logic             m_valid;
  logic [WIDTH-1:0] m_data;
  logic             m_oob;
  logic             m_perr;

  task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: update the model from the inputs seen at this edge, then
  // compare every output against it just after the edge.
  task automatic tick();
    int ra;
    int wa;
    ra = int'(bus.R0_addr);
    wa = int'(bus.W0_addr);
    if (!rst_n) begin
      m_init_left = DEPTH;
      m_valid = 1'b0;
      m_data  = '0;
      m_oob   = 1'b0;
      m_perr  = 1'b0;
    end else if (m_init_left > 0) begin
      m_mem[DEPTH - m_init_left]     = '0;
      m_corrupt[DEPTH - m_init_left] = 1'b0;
      m_init_left--;
      m_valid = 1'b0;
    end else begin
      if (bus.R0_en) begin
        m_valid = 1'b1;
        if (ra >= DEPTH) begin
          m_data = '0;
          m_oob  = 1'b1;
          m_perr = 1'b0;
        end else if (bus.W0_en && wa == ra) begin
          m_data = bus.W0_data;
          m_oob  = 1'b0;
          m_perr = 1'b0;
        end else begin
          m_data = m_mem[ra];
          m_oob  = 1'b0;
          m_perr = m_corrupt[ra];
        end
      end else begin
        m_valid = 1'b0;
      end
      if (bus.W0_en && wa < DEPTH) begin
        m_mem[wa]     = bus.W0_data;
        m_corrupt[wa] = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    chk("init_busy", bus.init_busy, m_init_left > 0);
    chk("W0_ready",  bus.W0_ready,  m_init_left == 0);
    chk("R0_valid",  bus.R0_valid,  m_valid);
    chk("R0_data",   bus.R0_data,   m_data);
    chk("R0_oob",    bus.R0_oob,    m_oob);
`ifdef RAM_PARITY_EN
    chk("R0_perr",   bus.R0_perr,   m_perr);
`endif
  endtask

  task automatic wr(input int addr, input logic [WIDTH-1:0] data);
    bus.W0_en   = 1'b1;
    bus.W0_addr = ADDR_W'(addr);
    bus.W0_data = data;
    tick();
    bus.W0_en   = 1'b0;
  endtask

  task automatic rd_expect(input string tag, input int addr, input logic [WIDTH-1:0] exp, input logic exp_oob);
    bus.R0_en   = 1'b1;
    bus.R0_addr = ADDR_W'(addr);
    tick();
    bus.R0_en   = 1'b0;
    chk({tag, "_valid"}, bus.R0_valid, 1'b1);
    chk({tag, "_data"},  bus.R0_data,  exp);
    chk({tag, "_oob"},   bus.R0_oob,   exp_oob);
  endtask

  task automatic run_init(input string tag);
    int cnt;
    cnt = 0;
    while (bus.init_busy === 1'b1 && cnt < 50) begin
      tick();
      cnt++;
    end
    chk(tag, cnt, DEPTH);
  endtask

  initial begin
    logic [95:0] rnd;
    rst_n       = 1'b0;
    bus.R0_en   = 1'b0;
    bus.R0_addr = '0;
    bus.W0_en   = 1'b0;
    bus.W0_addr = '0;
    bus.W0_data = '0;

    // Reset for two cycles
    tick();
    tick();

    // Release; request a write and a read during the sweep (both ignored)
    rst_n       = 1'b1;
    bus.W0_en   = 1'b1;
    bus.W0_addr = ADDR_W'(1);
    bus.W0_data = WIDTH'(3);
    bus.R0_en   = 1'b1;
    bus.R0_addr = ADDR_W'(1);
    run_init("init_len");
    bus.W0_en   = 1'b0;
    bus.R0_en   = 1'b0;
    tick();

    // All entries zero after the sweep, back-to-back reads
    for (int a = 0; a < DEPTH; a++) begin
      bus.R0_en   = 1'b1;
      bus.R0_addr = ADDR_W'(a);
      tick();
    end
    bus.R0_en = 1'b0;
    tick();

    // Write then read
    wr(3, 65'h1_DEAD_BEEF_0123_4567);
    rd_expect("rd3", 3, 65'h1_DEAD_BEEF_0123_4567, 1'b0);

    // Write-first bypass
    wr(2, 65'h5);
    bus.W0_en   = 1'b1;
    bus.W0_addr = ADDR_W'(2);
    bus.W0_data = 65'hA;
    bus.R0_en   = 1'b1;
    bus.R0_addr = ADDR_W'(2);
    tick();
    bus.W0_en = 1'b0;
    bus.R0_en = 1'b0;
    chk("bypass_data", bus.R0_data, 65'hA);
    rd_expect("after_bypass", 2, 65'hA, 1'b0);

    // Out of range
    wr(7, 65'hFF);
    rd_expect("oob7", 7, '0, 1'b1);
    rd_expect("rd0", 0, '0, 1'b0);

    // Write issued during init must not have landed
    rd_expect("init_blocked", 1, '0, 1'b0);

    // Reset mid-run with a read request in flight
    wr(4, 65'h77);
    bus.R0_en   = 1'b1;
    bus.R0_addr = ADDR_W'(4);
    rst_n       = 1'b0;
    tick();
    chk("abort_valid", bus.R0_valid, 1'b0);
    bus.R0_en = 1'b0;
    rst_n     = 1'b1;
    run_init("reinit_len");
    rd_expect("rd4_rezeroed", 4, '0, 1'b0);

    // Randomised traffic, model checked every cycle
    for (int i = 0; i < 400; i++) begin
      rnd         = {$urandom, $urandom, $urandom};
      bus.R0_en   = ($urandom_range(0, 3) != 0);
      bus.R0_addr = ADDR_W'($urandom_range(0, (1 << ADDR_W) - 1));
      bus.W0_en   = ($urandom_range(0, 1) != 0);
      bus.W0_addr = ($urandom_range(0, 3) == 0) ? bus.R0_addr
                                               : ADDR_W'($urandom_range(0, (1 << ADDR_W) - 1));
      bus.W0_data = rnd[WIDTH-1:0];
      tick();
    end
    bus.R0_en = 1'b0;
    bus.W0_en = 1'b0;
    tick();

`ifdef RAM_PARITY_EN
    // Flip one stored data bit behind the RAM's back
    wr(4, 65'h77);
    dut.r_mem[4][0] = ~dut.r_mem[4][0];
    m_mem[4][0]     = ~m_mem[4][0];
    m_corrupt[4]    = 1'b1;
    rd_expect("perr_rd4", 4, 65'h76, 1'b0);
    chk("perr_flag", bus.R0_perr, 1'b1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ram_data_sync_1r1w.md
Name: ram_data_sync_1r1w

Overview:
Parametrised single-clock 1-read/1-write data RAM for the megaboom data arrays. It supersedes the fixed-geometry combinational-read arrays.
- Registered read with a valid strobe.
- Write-first bypass on same-address read/write.
- Hardware zero-initialisation sweep after reset.
- Out-of-range address detection for non-power-of-two depths.

Parameters:
DEPTH, 7, number of entries (>=2, need not be a power of two)
WIDTH, 65, data bits per entry (>=1)
ADDR_W, max(1,$clog2(DEPTH)), address width; derived, not to be overridden

Ports:
clock  in  1  single clock for all state
reset_n  in  1  synchronous reset, active-low; one clock, sampled on posedge clock
init_busy  out  1  high while the zero-initialisation sweep runs
R0_en  in  1  read request
R0_addr  in  ADDR_W  read address
R0_valid  out  1  read data valid, one cycle after an accepted read
R0_data  out  WIDTH  registered read data
R0_oob  out  1  qualifies R0_valid: read address was >= DEPTH
W0_en  in  1  write request
W0_addr  in  ADDR_W  write address
W0_data  in  WIDTH  write data
W0_ready  out  1  writes accepted (low during init)

Behaviour:
- Reset (reset_n low at a posedge):
  - State = INIT, sweep pointer = 0.
  - init_busy=1, W0_ready=0, R0_valid=0, R0_data=0, R0_oob=0.
  - Memory contents are not touched by reset itself.
- FSM states INIT, RUN:
  - INIT: each cycle write WIDTH'b0 to Memory[ptr], then ptr++.
  - After writing entry DEPTH-1, the next state is RUN. The sweep therefore takes exactly DEPTH cycles after reset deasserts.
  - init_busy and W0_ready are combinational decodes of state: init_busy = (state==INIT), W0_ready = (state==RUN).
- INIT:
  - W0_en is ignored, with no side effects.
  - R0_en is ignored; R0_valid stays 0 and R0_data holds 0.
- RUN, write:
  - W0_en && W0_addr<DEPTH writes Memory[W0_addr] <= W0_data at the posedge.
  - W0_addr>=DEPTH: write dropped silently.
- RUN, read:
  - R0_en in cycle t causes R0_valid=1 in cycle t+1 for exactly one cycle.
  - R0_data is registered, so latency is 1.
  - In-range read: R0_data = Memory[R0_addr] as of cycle t, R0_oob=0.
  - R0_addr>=DEPTH: R0_data=0, R0_oob=1.
  - No read in cycle t: R0_valid=0 next cycle, and R0_data and R0_oob hold their previous values.
- Read-during-write, same cycle and same in-range address: write-first. R0_data returns that cycle's W0_data.
  - Different addresses are independent.
  - Back-to-back reads every cycle are supported, with one result per cycle.
- Reset mid-operation:
  - reset_n low in any state aborts in-flight reads (R0_valid=0 next cycle).
  - The FSM returns to INIT and the whole array is re-zeroed.
- No X is ever driven on R0_data.

Optional Feature:
RAM_PARITY_EN
- Defined:
  - Each entry stores WIDTH+1 bits; the extra bit is the even parity of the data, computed at write and stored as 0 by the init sweep.
  - Extra output port R0_perr (1 bit), valid with R0_valid. It is 1 when the recomputed parity of the stored data mismatches the stored bit.
  - A bypassed read reports R0_perr=0; an out-of-range read reports 0.
  - Reset value of R0_perr is 0.
- Undefined: no parity bit is stored and no R0_perr port exists; all other behaviour is identical.

Test Plan:
- Reset, DEPTH=7: release reset_n -> init_busy=1 and W0_ready=0 for exactly 7 cycles, then 0/1. Reading addresses 0..6 afterwards returns 0 each, with R0_valid one cycle after R0_en.
- Write/read: write addr 3 = 65'h1_DEAD_BEEF_0123_4567, then read addr 3 the next cycle -> R0_valid=1 one cycle later, R0_data=65'h1_DEAD_BEEF_0123_4567, R0_oob=0.
- Bypass: old value 65'h5 at addr 2; same cycle W0 addr 2 = 65'hA and R0 addr 2 -> R0_data=65'hA next cycle. A following read of addr 2 also gives 65'hA.
- Out-of-range, DEPTH=7: write addr 7 = 65'hFF, then read addr 7 -> R0_valid=1, R0_oob=1, R0_data=0. A read of addr 0 is unchanged (0).
- Init blocking: W0_en to addr 1 = 65'h3 during init_busy -> after init, read addr 1 returns 0. R0_en during init -> R0_valid stays 0.
- Reset mid-run: after writing addr 4 = 65'h77, pulse reset_n low one cycle while a read is in flight -> R0_valid=0, 7-cycle sweep reruns, and addr 4 reads 0. With RAM_PARITY_EN, force a flipped stored data bit -> R0_perr=1 on that read.
